// File: rtl/icache_lookup_refill.sv
// Lookup and refill controller for the 4-way, 8-set instruction cache.
// Keeps tag/valid state, reports hits to the PLRU and refills misses from memory by burst.
module icache_lookup_refill #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          core_req_valid,
  output logic                          core_req_ready,
  input  logic [ADDR_W-1:0]             core_req_addr,
  output logic                          core_hit_valid,
  output logic [3:0]                    core_hit_way,
  output logic [2:0]                    core_hit_set,
  output logic [$clog2(LINE_WORDS)-1:0] core_hit_word,
  input  logic                          flush,
  output logic                          plru_hit,
  output logic [2:0]                    hit_cache_line_addr,
  output logic [3:0]                    plru_hit_index,
  output logic [2:0]                    miss_cache_line_addr,
  input  logic [3:0]                    choose_old_onehot,
  output logic                          mem_req_valid,
  input  logic                          mem_req_ready,
  output logic [ADDR_W-1:0]             mem_req_addr,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_W-1:0]             mem_rsp_data,
  output logic                          data_we,
  output logic [3:0]                    data_way,
  output logic [2:0]                    data_set,
  output logic [$clog2(LINE_WORDS)-1:0] data_word,
  output logic [DATA_W-1:0]             data_wdata
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int SET_W = 3;
  localparam int NSETS = 8;
  localparam int WAYS  = 4;
  localparam int LO    = OFF_W + 2;
  localparam int TAG_W = ADDR_W - SET_W - LO;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOOKUP   = 2'd1,
    MISS_REQ = 2'd2,
    REFILL   = 2'd3
  } state_t;

  state_t                                state_r, state_nxt_s;
  logic [ADDR_W-1:0]                     addr_r;
  logic [NSETS-1:0][WAYS-1:0]            valid_r;
  logic [NSETS-1:0][WAYS-1:0][TAG_W-1:0] tag_r;
  logic [WAYS-1:0]                       victim_r;
  logic [OFF_W-1:0]                      cnt_r;
  logic                                  flush_pend_r;
  logic                                  hit_valid_r;
  logic [WAYS-1:0]                       hit_way_r;
  logic [SET_W-1:0]                      hit_set_r;
  logic [OFF_W-1:0]                      hit_word_r;

  logic [SET_W-1:0] set_s;
  logic [TAG_W-1:0] tag_s;
  logic [OFF_W-1:0] word_s;
  logic [WAYS-1:0]  match_s;
  logic lookup_hit_s, lookup_miss_s, flush_go_s, accept_s, beat_s, last_beat_s;
  logic unused_s;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // A PLRU answer that is not exactly one-hot falls back to way 0.
  function automatic logic [3:0] norm_victim(input logic [3:0] v);
    logic [3:0] r;
    if (is_onehot(v)) r = v;
    else              r = 4'b0001;
    return r;
  endfunction

  assign set_s    = addr_r[LO +: SET_W];
  assign tag_s    = addr_r[ADDR_W-1 -: TAG_W];
  assign word_s   = addr_r[2 +: OFF_W];
  assign unused_s = ^addr_r[1:0];

  // A pending or live flush blocks acceptance for the one IDLE cycle that applies it.
  assign flush_go_s     = (state_r == IDLE) && (flush || flush_pend_r);
  assign core_req_ready = (state_r == IDLE) && !flush && !flush_pend_r;
  assign accept_s       = core_req_valid && core_req_ready;
  assign lookup_hit_s   = (state_r == LOOKUP) && is_onehot(match_s);
  assign lookup_miss_s  = (state_r == LOOKUP) && !is_onehot(match_s);
  assign beat_s         = (state_r == REFILL) && mem_rsp_valid;
  assign last_beat_s    = beat_s && (cnt_r == OFF_W'(LINE_WORDS - 1));

  assign miss_cache_line_addr = set_s;
  assign mem_req_valid        = (state_r == MISS_REQ);
  assign core_hit_valid       = hit_valid_r;
  assign core_hit_way         = hit_way_r;
  assign core_hit_set         = hit_set_r;
  assign core_hit_word        = hit_word_r;
  assign plru_hit             = hit_valid_r;
  assign plru_hit_index       = hit_way_r;
  assign hit_cache_line_addr  = hit_set_r;

  // Per-way tag compare against the latched address.
  always_comb begin
    match_s = '0;
    for (int w = 0; w < WAYS; w++) begin
      match_s[w] = valid_r[set_s][w] && (tag_r[set_s][w] == tag_s);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:     if (accept_s) state_nxt_s = LOOKUP;      else state_nxt_s = IDLE;
      LOOKUP:   if (lookup_hit_s) state_nxt_s = IDLE;    else state_nxt_s = MISS_REQ;
      MISS_REQ: if (mem_req_ready) state_nxt_s = REFILL; else state_nxt_s = MISS_REQ;
      REFILL:   if (last_beat_s) state_nxt_s = LOOKUP;   else state_nxt_s = REFILL;
      default:  state_nxt_s = IDLE;
    endcase
  end

  // Memory request address and data RAM write decode, zero when not strobed.
  always_comb begin
    mem_req_addr = '0;
    data_we      = 1'b0;
    data_way     = '0;
    data_set     = '0;
    data_word    = '0;
    data_wdata   = '0;
    if (mem_req_valid) begin
      mem_req_addr = {addr_r[ADDR_W-1:LO], {LO{1'b0}}};
    end else begin
      mem_req_addr = '0;
    end
    if (beat_s) begin
      data_we    = 1'b1;
      data_way   = victim_r;
      data_set   = set_s;
      data_word  = cnt_r;
      data_wdata = mem_rsp_data;
    end else begin
      data_we    = 1'b0;
    end
  end

  // Control registers: state, latched request, victim, beat counter, flush and hit pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      addr_r       <= '0;
      victim_r     <= '0;
      cnt_r        <= '0;
      flush_pend_r <= 1'b0;
      hit_valid_r  <= 1'b0;
      hit_way_r    <= '0;
      hit_set_r    <= '0;
      hit_word_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) addr_r <= core_req_addr;
      if (state_r == IDLE) flush_pend_r <= 1'b0;
      else if (flush)      flush_pend_r <= 1'b1;
      if (lookup_miss_s) victim_r <= norm_victim(choose_old_onehot);
      if (state_r == MISS_REQ) cnt_r <= '0;
      else if (beat_s)         cnt_r <= cnt_r + OFF_W'(1);
      hit_valid_r <= lookup_hit_s;
      hit_way_r   <= lookup_hit_s ? match_s : '0;
      hit_set_r   <= lookup_hit_s ? set_s : '0;
      hit_word_r  <= lookup_hit_s ? word_s : '0;
    end
  end

  // Tag and valid arrays: a missing way is invalidated until its last beat lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= '0;
      tag_r   <= '0;
    end else if (flush_go_s) begin
      valid_r <= '0;
    end else if (lookup_miss_s) begin
      valid_r[set_s] <= valid_r[set_s] & ~norm_victim(choose_old_onehot);
    end else if (last_beat_s) begin
      valid_r[set_s] <= valid_r[set_s] | victim_r;
      for (int w = 0; w < WAYS; w++) begin
        if (victim_r[w]) tag_r[set_s][w] <= tag_s;
      end
    end
  end
endmodule

// File: tb/tb_icache_lookup_refill.sv
// Directed bench for icache_lookup_refill: a cache-content model predicts hits, refill
// writes and latencies; a per-cycle compare process checks the DUT against it.
module tb_icache_lookup_refill;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req_valid = 1'b0;
  logic        core_req_ready;
  logic [31:0] core_req_addr = 32'd0;
  logic        core_hit_valid;
  logic [3:0]  core_hit_way;
  logic [2:0]  core_hit_set;
  logic [1:0]  core_hit_word;
  logic        flush = 1'b0;
  logic        plru_hit;
  logic [2:0]  hit_cache_line_addr;
  logic [3:0]  plru_hit_index;
  logic [2:0]  miss_cache_line_addr;
  logic [3:0]  choose_old_onehot = 4'd0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'd0;
  logic        data_we;
  logic [3:0]  data_way;
  logic [2:0]  data_set;
  logic [1:0]  data_word;
  logic [31:0] data_wdata;

  icache_lookup_refill dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready), .core_req_addr(core_req_addr),
    .core_hit_valid(core_hit_valid), .core_hit_way(core_hit_way), .core_hit_set(core_hit_set),
    .core_hit_word(core_hit_word), .flush(flush), .plru_hit(plru_hit),
    .hit_cache_line_addr(hit_cache_line_addr), .plru_hit_index(plru_hit_index),
    .miss_cache_line_addr(miss_cache_line_addr), .choose_old_onehot(choose_old_onehot),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .data_we(data_we), .data_way(data_way), .data_set(data_set), .data_word(data_word),
    .data_wdata(data_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] way; logic [2:0] set; logic [1:0] word; } hit_t;
  typedef struct packed { logic [3:0] way; logic [2:0] set; logic [1:0] word; logic [31:0] data; } wr_t;

  int   n_chk = 0;
  int   n_fail = 0;
  hit_t exp_hit[$];
  wr_t  exp_wr[$];
  bit   exp_mem_on = 1'b0;
  logic [31:0] exp_mem_addr = 32'd0;
  bit   cmp_on = 1'b0;
  logic [24:0] m_tag [8][4];
  bit          m_val [8][4];
  logic [3:0]  obs_hit_way;
  logic [2:0]  obs_hit_set;
  logic [1:0]  obs_hit_word;
  logic [31:0] obs_mem_addr;
  logic [3:0]  obs_wr_way;
  logic [31:0] obs_wr_data;
  int          obs_wr_cnt = 0;
  int          last_lat = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 4; w++) m_val[s][w] = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, " ready"}, core_req_ready, 1'b1);
    chk({tag, " hit/plru outs"}, {core_hit_valid, core_hit_way, core_hit_set, core_hit_word, plru_hit,
        hit_cache_line_addr, plru_hit_index, miss_cache_line_addr}, 64'd0);
    chk({tag, " mem outs"}, {mem_req_valid, mem_req_addr}, 64'd0);
    chk({tag, " data outs"}, {data_we, data_way, data_set, data_word, data_wdata}, 64'd0);
  endtask

  // Per-cycle compare of strobed outputs against the model's expectation queues.
  initial begin : compare
    hit_t h;
    wr_t  w;
    forever begin
      @(negedge clk);
      if (rst_n && cmp_on) begin
        if (core_hit_valid) begin
          obs_hit_way = core_hit_way; obs_hit_set = core_hit_set; obs_hit_word = core_hit_word;
          chk("hit expected", exp_hit.size() != 0, 1'b1);
          if (exp_hit.size() != 0) begin
            h = exp_hit.pop_front();
            chk("hit way", core_hit_way, h.way);
            chk("hit set", core_hit_set, h.set);
            chk("hit word", core_hit_word, h.word);
            chk("plru_hit", plru_hit, 1'b1);
            chk("plru index", plru_hit_index, h.way);
            chk("plru set", hit_cache_line_addr, h.set);
          end
        end else begin
          chk("hit outs quiet", {core_hit_way, core_hit_set, core_hit_word, plru_hit, plru_hit_index,
              hit_cache_line_addr}, 64'd0);
        end
        if (data_we) begin
          obs_wr_cnt++; obs_wr_way = data_way; obs_wr_data = data_wdata;
          chk("write expected", exp_wr.size() != 0, 1'b1);
          chk("ready low in refill", core_req_ready, 1'b0);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            chk("write way", data_way, w.way);
            chk("write set", data_set, w.set);
            chk("write word", data_word, w.word);
            chk("write data", data_wdata, w.data);
          end
        end else begin
          chk("data outs quiet", {data_way, data_set, data_word, data_wdata}, 64'd0);
        end
        if (mem_req_valid) begin
          obs_mem_addr = mem_req_addr;
          chk("mem req expected", exp_mem_on, 1'b1);
          chk("mem req addr", mem_req_addr, exp_mem_addr);
          chk("miss set", miss_cache_line_addr, exp_mem_addr[6:4]);
          chk("ready low in miss", core_req_ready, 1'b0);
        end else begin
          chk("mem addr quiet", mem_req_addr, 64'd0);
        end
      end
    end
  end

  task automatic issue(input logic [31:0] addr, output bit acc);
    acc = 1'b0;
    @(posedge clk); #1;
    core_req_valid = 1'b1;
    core_req_addr  = addr;
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = core_req_ready;
      @(posedge clk); #1;
    end
    core_req_valid = 1'b0;
    core_req_addr  = ~addr;
    chk("request accepted", acc, 1'b1);
  endtask

  task automatic mem_serve(input int lat, input int rdel, input int nbeats, input logic [31:0] dbase, input int fbeat);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_req_valid && n < 50);
    chk("mem req seen", mem_req_valid, 1'b1);
    if (mem_req_valid) begin
      mem_rsp_valid = (rdel > 0);
      mem_rsp_data  = 32'hDEAD_BEEF;
      repeat (rdel) @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b1;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      repeat (lat - 1) begin @(posedge clk); #1; end
      for (int b = 0; b < nbeats; b++) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = dbase + 32'(b);
        flush         = (b == fbeat);
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b0;
      flush         = 1'b0;
    end
  endtask

  task automatic access(input logic [31:0] addr, input logic [3:0] vic, input int lat, input int rdel,
                        input logic [31:0] dbase, input int fbeat);
    logic [2:0] s; logic [24:0] t; logic [1:0] wd; logic [3:0] hw, v;
    int exp_lat, n; bit acc, hit;
    s = addr[6:4]; t = addr[31:7]; wd = addr[3:2];
    hw = 4'd0;
    for (int w = 0; w < 4; w++) if (m_val[s][w] && m_tag[s][w] == t) hw[w] = 1'b1;
    hit = (hw != 4'd0);
    obs_wr_cnt = 0;
    if (hit) begin
      exp_hit.push_back(hit_t'{hw, s, wd});
      exp_lat = 2;
    end else begin
      v = ($countones(vic) == 1) ? vic : 4'b0001;
      exp_mem_on = 1'b1;
      exp_mem_addr = {addr[31:4], 4'd0};
      for (int b = 0; b < 4; b++) exp_wr.push_back(wr_t'{v, s, 2'(b), dbase + 32'(b)});
      exp_hit.push_back(hit_t'{v, s, wd});
      exp_lat = 3 + lat + 4 + rdel;
      for (int w = 0; w < 4; w++) if (v[w]) begin m_tag[s][w] = t; m_val[s][w] = 1'b1; end
    end
    choose_old_onehot = vic;
    issue(addr, acc);
    if (acc) begin
      fork
        if (!hit) mem_serve(lat, rdel, 4, dbase, fbeat);
        begin
          n = 0;
          do begin
            @(negedge clk); n++;
            if (!core_hit_valid) chk("ready low while busy", core_req_ready, 1'b0);
          end while (!core_hit_valid && n < 300);
          chk("hit latency", n, exp_lat);
          chk("ready at hit cycle", core_req_ready, fbeat < 0);
          last_lat = n;
        end
      join
    end
    #1;
    exp_mem_on = 1'b0;
    if (fbeat >= 0) m_clear();
    chk("queues drained", exp_hit.size() + exp_wr.size(), 64'd0);
    exp_hit.delete();
    exp_wr.delete();
  endtask

  initial begin : stim
    bit acc;
    m_clear();
    @(negedge clk);
    check_reset_outs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cmp_on = 1'b1;

    // First fetch misses into way 0 of set 4.
    access(32'h0000_0040, 4'b0001, 1, 0, 32'hA0, -1);
    chk("t1 mem addr", obs_mem_addr, 32'h40);
    chk("t1 write count", obs_wr_cnt, 4);
    chk("t1 last wdata", obs_wr_data, 32'hA3);
    chk("t1 hit way", obs_hit_way, 4'b0001);
    chk("t1 hit set", obs_hit_set, 3'd4);
    chk("t1 hit word", obs_hit_word, 2'd0);
    chk("t1 latency", last_lat, 8);

    access(32'h0000_0048, 4'b0100, 1, 0, 32'h0, -1);
    chk("t2 latency", last_lat, 2);
    chk("t2 no refill", obs_wr_cnt, 0);
    chk("t2 hit word", obs_hit_word, 2'd2);
    chk("t2 hit set", obs_hit_set, 3'd4);

    // Fill set 4 with distinct tags; the fifth victim reuses way 1.
    access(32'h0000_00C0, 4'b0010, 2, 0, 32'h100, -1);
    access(32'h0000_0140, 4'b0100, 3, 0, 32'h200, -1);
    access(32'h0000_01C0, 4'b1000, 1, 0, 32'h300, -1);
    access(32'h0000_0240, 4'b0010, 1, 0, 32'h400, -1);
    chk("fill5 way", obs_wr_way, 4'b0010);
    access(32'h0000_00C4, 4'b0000, 1, 0, 32'h500, -1);
    chk("evicted tag misses", obs_wr_cnt, 4);
    chk("zero victim -> way0", obs_wr_way, 4'b0001);
    access(32'h0000_004C, 4'b0110, 1, 0, 32'h600, -1);
    chk("multi-hot victim -> way0", obs_wr_way, 4'b0001);
    access(32'h0000_01C0, 4'b0001, 1, 0, 32'h0, -1);
    chk("way3 still hits", obs_hit_way, 4'b1000);

    // Memory holds off the request for 10 cycles with stray beats.
    access(32'h0000_0300, 4'b0100, 1, 10, 32'h700, -1);
    chk("stalled latency", last_lat, 18);

    // Flush during refill: replay still hits, then the line is gone.
    access(32'h0000_0400, 4'b0001, 1, 0, 32'h800, 1);
    access(32'h0000_0400, 4'b0001, 1, 0, 32'h900, -1);
    chk("flushed line refetched", obs_wr_cnt, 4);

    // Flush in IDLE blocks the coincident request and drops resident lines.
    @(posedge clk); #1;
    flush = 1'b1; core_req_valid = 1'b1; core_req_addr = 32'h0000_0400;
    @(negedge clk);
    chk("ready low on idle flush", core_req_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; core_req_valid = 1'b0;
    m_clear();
    access(32'h0000_0400, 4'b0010, 1, 0, 32'hA00, -1);
    chk("idle flush misses", obs_wr_cnt, 4);

    // Reset after three beats of a refill.
    choose_old_onehot = 4'b1000;
    exp_mem_on = 1'b1;
    exp_mem_addr = 32'h0000_0500;
    for (int b = 0; b < 3; b++) exp_wr.push_back(wr_t'{4'b1000, 3'd0, 2'(b), 32'hC0 + 32'(b)});
    issue(32'h0000_0500, acc);
    if (acc) mem_serve(1, 0, 3, 32'hC0, -1);
    rst_n = 1'b0;
    exp_mem_on = 1'b0;
    core_req_valid = 1'b0;
    @(negedge clk);
    check_reset_outs("mid-refill reset");
    chk("beats before reset", exp_wr.size(), 64'd0);
    exp_wr.delete();
    exp_hit.delete();
    m_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(32'h0000_0500, 4'b1000, 1, 0, 32'hC8, -1);
    chk("post-reset refetch", obs_wr_cnt, 4);
    chk("post-reset mem addr", obs_mem_addr, 32'h500);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
